// File: rtl/od_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : od_serial_rx_if
// Description : Monitor-side bundle of the open-drain serial word receiver.
//               Carries the received word with its valid/ready handshake and
//               the receiver status/error pulses.
//   word        : last accepted word, first received bit in MSB
//   word_valid  : word holds an unconsumed value
//   word_ready  : consumer accepts word when word_valid & word_ready
//   busy        : receiver not idle
//   err_frame   : 1-cycle pulse, frame ended with wrong bit count
//   err_overrun : 1-cycle pulse, good word dropped because buffer was full
//   master      : receiver side; slave : consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface od_serial_rx_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             word_ready;
   logic             busy;
   logic             err_frame;
   logic             err_overrun;

   modport master (
      output word, word_valid, busy, err_frame, err_overrun,
      input  word_ready
   );

   modport slave (
      input  word, word_valid, busy, err_frame, err_overrun,
      output word_ready
   );
endinterface
`default_nettype wire

// File: rtl/od_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : od_serial_rx
// Description : Receive end of the open-drain serial word link. The three
//               active-low pulled-up lines are synchronized, deglitched and
//               shifted into a WIDTH-bit word, which is handed to the monitor
//               side over a valid/ready handshake.
//   clk    : system clock, rising edge
//   rst    : synchronous active-low reset
//   sync_n : frame line, low = frame active (async)
//   bclk_n : bit strobe, falling edge = data valid (async)
//   dat_n  : data line, low = logic 1 (async)
//   mon    : monitor-side bundle (word, handshake, status, errors)
// Revision    : 1.0 - initial release
// ============================================================================
module od_serial_rx #(
   parameter int WIDTH = 16,
   parameter int FILT  = 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       sync_n,
   input  wire logic       bclk_n,
   input  wire logic       dat_n,
   od_serial_rx_if.master  mon
);
   localparam int CW     = $clog2(WIDTH + 1);
   localparam int FW     = $clog2(FILT + 1);
   localparam int L_SYNC = 0;
   localparam int L_BCLK = 1;
   localparam int L_DAT  = 2;
   // Filtered reset levels: frame asserted (0), strobe and data idle-high.
   localparam logic [2:0] FILT_RST = 3'b110;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_SHIFT = 2'd2,
      S_END   = 2'd3
   } state_t;

   logic [2:0]          pin;
   logic [2:0]          s1_q, s1_d, s2_q, s2_d, filt_q, filt_d;
   logic [1:0]          prev_q, prev_d;
   logic [2:0][FW-1:0]  fcnt_q, fcnt_d;
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [WIDTH-1:0]    word_q, word_d;
   logic                word_valid_q, word_valid_d;
   logic                err_frame_q, err_frame_d;
   logic                err_overrun_q, err_overrun_d;
   logic                sync_fall, sync_rise, bclk_fall;

   assign pin = {dat_n, bclk_n, sync_n};

   // Input path: 2-FF synchronizer then a stability filter per line. The
   // filtered level only follows once the synchronized level has disagreed
   // for FILT consecutive cycles, so shorter pulses are swallowed.
   always_comb begin
      s1_d   = pin;
      s2_d   = s1_q;
      filt_d = filt_q;
      prev_d = filt_q[1:0];
      fcnt_d = '0;
      for (int i = 0; i < 3; i++) begin
         if (s2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FW'(FILT - 1)) begin
               filt_d[i] = s2_q[i];
            end else begin
               fcnt_d[i] = fcnt_q[i] + FW'(1);
            end
         end
      end
   end

   // Edges are taken from the registered filtered levels, one cycle after
   // the filter output changes.
   assign sync_fall = prev_q[L_SYNC] & ~filt_q[L_SYNC];
   assign sync_rise = ~prev_q[L_SYNC] & filt_q[L_SYNC];
   assign bclk_fall = prev_q[L_BCLK] & ~filt_q[L_BCLK];

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ovf_d         = ovf_q;
      shift_d       = shift_q;
      word_d        = word_q;
      word_valid_d  = word_valid_q & ~mon.word_ready;
      err_frame_d   = 1'b0;
      err_overrun_d = 1'b0;
      case (state_q)
         S_WAIT: begin
            // A frame already active when reset lifts is not joined mid-way.
            if (filt_q[L_SYNC]) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (sync_fall) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               shift_d = '0;
            end
         end
         S_SHIFT: begin
            if (bclk_fall) begin
               if (cnt_q == CW'(WIDTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  shift_d = {shift_q[WIDTH-2:0], ~filt_q[L_DAT]};
                  cnt_d   = cnt_q + CW'(1);
               end
            end
            if (sync_rise) state_d = S_END;
         end
         S_END: begin
            state_d = S_IDLE;
            if ((cnt_q == CW'(WIDTH)) && !ovf_q) begin
               if (!word_valid_q || mon.word_ready) begin
                  word_d       = shift_q;
                  word_valid_d = 1'b1;
               end else begin
                  err_overrun_d = 1'b1;
               end
            end else begin
               err_frame_d = 1'b1;
            end
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q          <= '1;
         s2_q          <= '1;
         filt_q        <= FILT_RST;
         prev_q        <= FILT_RST[1:0];
         fcnt_q        <= '0;
         state_q       <= S_WAIT;
         cnt_q         <= '0;
         ovf_q         <= 1'b0;
         shift_q       <= '0;
         word_q        <= '0;
         word_valid_q  <= 1'b0;
         err_frame_q   <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         filt_q        <= filt_d;
         prev_q        <= prev_d;
         fcnt_q        <= fcnt_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ovf_q         <= ovf_d;
         shift_q       <= shift_d;
         word_q        <= word_d;
         word_valid_q  <= word_valid_d;
         err_frame_q   <= err_frame_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign mon.word        = word_q;
   assign mon.word_valid  = word_valid_q;
   assign mon.err_frame   = err_frame_q;
   assign mon.err_overrun = err_overrun_q;
   assign mon.busy        = (state_q != S_IDLE) | ~rst;
endmodule
`default_nettype wire
